// File: rtl/ad_spi_cfg.sv
// Power-up configuration sequencer for the dual 14-bit ADC: writes a fixed
// register table over the 3-wire SPI port after reset, or again on a start pulse.
`timescale 1ns / 1ps

module ad_spi_cfg #(
   parameter int CLK_DIV   = 4,     // CLK cycles per SCLK half-period, >= 2
   parameter int PWRUP_CYC = 1000,  // >= 1
   parameter int GAP_CYC   = 8,     // >= 1
   parameter int NUM_REGS  = 4
) (
   input  logic       CLK,
   input  logic       Rst,
   input  logic       start,
   output logic       ADA_SPI_CS,
   output logic       AD_SCLK,
   output logic       AD_SDIO,
   output logic       busy,
   output logic       cfg_done,
   output logic [2:0] dbg_state_o
);

   localparam int HALF_W   = $clog2(CLK_DIV) + 1;
   localparam int WAIT_MAX = (PWRUP_CYC > GAP_CYC) ? PWRUP_CYC : GAP_CYC;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(CLK_DIV - 1);
   localparam logic [WAIT_W-1:0] PWRUP_LAST = WAIT_W'(PWRUP_CYC - 1);
   localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(GAP_CYC - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_REGS - 1);
   localparam logic [4:0]        BIT_LAST   = 5'd23;

   typedef enum logic [2:0] {
      S_PWRUP    = 3'd0,
      S_LOAD     = 3'd1,
      S_CS_SETUP = 3'd2,
      S_SHIFT    = 3'd3,
      S_CS_HOLD  = 3'd4,
      S_GAP      = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   state_t              state_q;
   logic [WAIT_W-1:0]   wait_q;
   logic [HALF_W-1:0]   half_q;
   logic [4:0]          bit_q;
   logic [IDX_W-1:0]    idx_q;
   logic [23:0]         sh_q;
   logic                cs_q;
   logic                sclk_q;
   logic                sdio_q;
   logic                busy_q;
   logic                done_q;
   logic [23:0]         tbl_word;

   // Frame layout: R/W=0, W1:W0=00 (single data byte), 13-bit address, data.
   function automatic logic [23:0] cfg_word(input logic [IDX_W-1:0] i);
      logic [12:0] addr;
      logic [7:0]  data;
      case (8'(i))
         8'd0:    begin addr = 13'h000; data = 8'h18; end  // MSB first, SDO config
         8'd1:    begin addr = 13'h014; data = 8'h01; end  // two's-complement output
         8'd2:    begin addr = 13'h016; data = 8'h00; end  // default clock phase
         8'd3:    begin addr = 13'h0FF; data = 8'h01; end  // transfer / latch
         default: begin addr = 13'h000; data = 8'h00; end
      endcase
      return {1'b0, 2'b00, addr, data};
   endfunction

   assign tbl_word = cfg_word(idx_q);

   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         state_q <= S_PWRUP;
         wait_q  <= '0;
         half_q  <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b0;
         sdio_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_PWRUP: begin
               busy_q <= 1'b1;
               if (wait_q == PWRUP_LAST) begin
                  wait_q  <= '0;
                  state_q <= S_LOAD;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end

            S_LOAD: begin
               sh_q    <= tbl_word;
               sdio_q  <= tbl_word[23];
               cs_q    <= 1'b0;
               half_q  <= '0;
               bit_q   <= '0;
               state_q <= S_CS_SETUP;
            end

            S_CS_SETUP: begin
               if (half_q == HALF_LAST) begin
                  half_q  <= '0;
                  sclk_q  <= 1'b1;
                  state_q <= S_SHIFT;
               end else begin
                  half_q <= half_q + 1'b1;
               end
            end

            // Each bit is one full SCLK period: high half, then low half.
            // Data moves on the falling edge so it is stable for CLK_DIV
            // cycles before the ADC samples it on the next rising edge.
            S_SHIFT: begin
               if (half_q == HALF_LAST) begin
                  half_q <= '0;
                  if (sclk_q) begin
                     sclk_q <= 1'b0;
                     sh_q   <= {sh_q[22:0], 1'b0};
                     sdio_q <= (bit_q == BIT_LAST) ? 1'b0 : sh_q[22];
                  end else if (bit_q == BIT_LAST) begin
                     state_q <= S_CS_HOLD;
                  end else begin
                     sclk_q <= 1'b1;
                     bit_q  <= bit_q + 5'd1;
                  end
               end else begin
                  half_q <= half_q + 1'b1;
               end
            end

            S_CS_HOLD: begin
               if (half_q == HALF_LAST) begin
                  half_q  <= '0;
                  cs_q    <= 1'b1;
                  wait_q  <= '0;
                  state_q <= S_GAP;
               end else begin
                  half_q <= half_q + 1'b1;
               end
            end

            // idx saturates at the last entry; DONE is terminal until start.
            S_GAP: begin
               if (wait_q == GAP_LAST) begin
                  wait_q <= '0;
                  if (idx_q == IDX_LAST) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= S_LOAD;
                  end
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end

            S_DONE: begin
               if (start) begin
                  idx_q   <= '0;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end

            default: begin
               state_q <= S_PWRUP;
            end
         endcase
      end
   end

   assign ADA_SPI_CS  = cs_q;
   assign AD_SCLK     = sclk_q;
   assign AD_SDIO     = sdio_q;
   assign busy        = busy_q;
   assign cfg_done    = done_q;
   assign dbg_state_o = state_q;

endmodule
